// File: rtl/da_amp_sequencer.sv
// da_amp_sequencer: round-robin serial DAC update sequencer for two 12-bit
// amplitude channels (A, B). Tracks the code last sent per channel and ships a
// 16-bit frame {ch, 3'b000, code[11:0]} whenever a channel differs from its
// synchronized target. One frame in flight at a time.
// Optional feature macro: DA_AMP_RAMP_EN -- slew limiting (STEP codes per
// frame) and tick pacing (one frame per channel per TICK_DIV-cycle tick).
// Debug: state_o exposes the FSM state (0=IDLE 1=LOAD 2=SHIFT 3=GAP).
module da_amp_sequencer #(
  parameter int CLK_DIV  = 4,
  parameter int STEP     = 16,
  parameter int TICK_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] amp_a_i,
  input  logic [11:0] amp_b_i,
  output logic        dac_cs_n_o,
  output logic        dac_sclk_o,
  output logic        dac_din_o,
  output logic        busy_o,
  output logic [11:0] cur_a_o,
  output logic [11:0] cur_b_o,
  output logic [1:0]  state_o
);

  // Reject configurations the counters and ramp arithmetic cannot represent.
  if (CLK_DIV < 1 || STEP < 1 || STEP > 4095 || TICK_DIV < 2) begin : g_bad_cfg
    $error("da_amp_sequencer: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, GAP = 2'd3} state_t;

  localparam int CW = $clog2(2 * CLK_DIV + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;      // CLK cycles within a half-period / gap
  logic [4:0]    phase_q, phase_d;  // SCLK half-period index, even = high
  logic [15:0]   sh_q, sh_d;        // frame word, MSB is on the wire
  logic          win_q, win_d;      // channel of the frame in flight (1 = B)
  logic [11:0]   next_q, next_d;    // code carried by the frame in flight
  logic          ptr_q, ptr_d;      // round-robin preference (1 = B)
  logic [11:0]   sync_a_q, ta_q, sync_b_q, tb_q;
  logic [11:0]   cur_a_q, cur_b_q;
  logic          cs_n_q, sclk_q, din_q, busy_q;
  logic          pend_a, pend_b, win_c, load, commit;
  logic [11:0]   na, nb;

`ifdef DA_AMP_RAMP_EN
  localparam int TW = $clog2(TICK_DIV);
  localparam logic signed [12:0] STEP_S = 13'(STEP);

  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  logic [1:0]    seen_q, seen_d;    // a tick fired since the channel's last load

  // Move at most STEP codes toward the target; 13-bit signed so no wrap.
  function automatic logic [11:0] ramp_next(input logic [11:0] tgt, input logic [11:0] cur);
    logic signed [12:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > STEP_S)       return cur + 12'(STEP);
    else if (diff < -STEP_S) return cur - 12'(STEP);
    else                     return tgt;
  endfunction

  assign tick   = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign pend_a = seen_q[0] && (ta_q != cur_a_q);
  assign pend_b = seen_q[1] && (tb_q != cur_b_q);
  assign na     = ramp_next(ta_q, cur_a_q);
  assign nb     = ramp_next(tb_q, cur_b_q);

  // Tick flags: a tick sets both, loading a channel clears its own (clear wins).
  always_comb begin
    seen_d = seen_q | {tick, tick};
    if (load) seen_d[win_c] = 1'b0;
  end

  // Free-running tick counter, independent of the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      seen_q     <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      seen_q     <= seen_d;
    end
  end
`else
  assign pend_a = (ta_q != cur_a_q);
  assign pend_b = (tb_q != cur_b_q);
  assign na     = ta_q;
  assign nb     = tb_q;
`endif

  // Both pending: pointer decides; otherwise the lone pending channel wins.
  assign win_c  = (pend_a && pend_b) ? ptr_q : pend_b;
  assign commit = (state_q == SHIFT) && (state_d == GAP);

  // Next-state logic: frame sequencing and bit-serial shift pacing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    sh_d    = sh_q;
    win_d   = win_q;
    next_d  = next_q;
    ptr_d   = ptr_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_a || pend_b) begin
          state_d = LOAD;
          load    = 1'b1;
          win_d   = win_c;
          next_d  = win_c ? nb : na;
          sh_d    = {win_c, 3'b000, (win_c ? nb : na)};
          ptr_d   = ~ptr_q;
          cnt_d   = '0;
          phase_d = '0;
        end
      end
      LOAD: begin
        state_d = SHIFT;
        cnt_d   = '0;
        phase_d = '0;
      end
      SHIFT: begin
        // First low cycle of SCLK: present the next bit one cycle later.
        if (phase_q[0] && cnt_q == '0) sh_d = {sh_q[14:0], 1'b0};
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (phase_q == 5'd31) state_d = GAP;
          else                  phase_d = phase_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CW'(2 * CLK_DIV - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Two-flop target synchronizers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a_q <= '0;
      ta_q     <= '0;
      sync_b_q <= '0;
      tb_q     <= '0;
    end else begin
      sync_a_q <= amp_a_i;
      ta_q     <= sync_a_q;
      sync_b_q <= amp_b_i;
      tb_q     <= sync_b_q;
    end
  end

  // FSM/datapath registers; DAC pins registered from next state (glitch-free).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phase_q <= '0;
      sh_q    <= '0;
      win_q   <= 1'b0;
      next_q  <= '0;
      ptr_q   <= 1'b0;
      cur_a_q <= '0;
      cur_b_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      din_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      sh_q    <= sh_d;
      win_q   <= win_d;
      next_q  <= next_d;
      ptr_q   <= ptr_d;
      if (commit && !win_q) cur_a_q <= next_q;
      if (commit &&  win_q) cur_b_q <= next_q;
      cs_n_q  <= (state_d != SHIFT);
      sclk_q  <= (state_d == SHIFT) && !phase_d[0];
      din_q   <= (state_d == SHIFT) && sh_d[15];
      busy_q  <= (state_d != IDLE);
    end
  end

  assign dac_cs_n_o = cs_n_q;
  assign dac_sclk_o = sclk_q;
  assign dac_din_o  = din_q;
  assign busy_o     = busy_q;
  assign cur_a_o    = cur_a_q;
  assign cur_b_o    = cur_b_q;
  assign state_o    = state_q;

endmodule
